// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_pkg;

    localparam int IF_ADDR_W = 32;
    localparam int IF_DATA_W = 32;

    // addi x0, x0, 0 -- what decode sees whenever IF/ID holds no real instruction
    localparam logic [IF_DATA_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // IF/ID pipeline register contents, also consumed by the decode stage
    typedef struct packed {
        logic                 valid;
        logic [IF_DATA_W-1:0] instr;
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_ADDR_W-1:0] pc_plus4;
    } if_id_t;

    // Empty-slot value: no valid instruction, NOP in the instruction field
    function automatic if_id_t if_id_empty();
        if_id_t r;
        r.valid    = 1'b0;
        r.instr    = NOP;
        r.pc       = '0;
        r.pc_plus4 = '0;
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load a new fetch, flush to an empty slot, or hold.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   flush,
    input  if_id_t load_data,
    output if_id_t if_id
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    // Flush wins over load; flush empties the slot but leaves the pc fields as they were
    always_comb begin
        if_id_d = if_id_q;
        if (flush) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP;
        end else if (load) begin
            if_id_d = load_data;
        end
    end

    // Register with asynchronous return to the empty slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_q <= if_id_empty();
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id = if_id_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses the single-cycle ROM and fills IF/ID.
// Faults (misaligned redirect, fetch past the ROM) are sticky until reset.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      ADDR_WIDTH      = 32,
    parameter int                      DATA_WIDTH      = 32,
    parameter int                      MEM_DEPTH_BYTES = 1024,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC        = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    input  logic [DATA_WIDTH-1:0] instruction_data,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  if_id_valid,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
    output logic                  fetch_fault,
    output logic [31:0]           fetch_count
);

    // Highest word address that still lies fully inside the ROM
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH_BYTES - 4);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           fetch_count_q, fetch_count_d;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  if_id_load;
    logic                  if_id_flush;
    if_id_t                if_id_next;
    if_id_t                if_id;

    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

    // Next PC / state / count and IF/ID control, in redirect > stall > range-check priority
    always_comb begin
        state_d             = state_q;
        pc_d                = pc_q;
        fetch_count_d       = fetch_count_q;
        if_id_load          = 1'b0;
        if_id_flush         = 1'b0;
        if_id_next.valid    = 1'b1;
        if_id_next.instr    = instruction_data;
        if_id_next.pc       = pc_q;
        if_id_next.pc_plus4 = pc_plus4;
        case (state_q)
            RUN: begin
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    state_d     = FAULT;
                    if_id_flush = 1'b1;
                end else if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    if_id_flush = 1'b1;
                end else if (stall) begin
                    // everything holds
                end else if (pc_q > LAST_ADDR) begin
                    state_d     = FAULT;
                    if_id_flush = 1'b1;
                end else begin
                    if_id_load    = 1'b1;
                    pc_d          = pc_plus4;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            FAULT: begin
                // frozen until reset; keep IF/ID empty
                if_id_flush = 1'b1;
            end
            default: begin
                state_d     = FAULT;
                if_id_flush = 1'b1;
            end
        endcase
    end

    // State, PC and delivery counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (if_id_load),
        .flush     (if_id_flush),
        .load_data (if_id_next),
        .if_id     (if_id)
    );

    assign instruction_address = pc_q;
    assign if_id_valid         = if_id.valid;
    assign if_id_instr         = if_id.instr;
    assign if_id_pc            = if_id.pc;
    assign if_id_pc_plus4      = if_id.pc_plus4;
    assign fetch_fault         = (state_q == FAULT);
    assign fetch_count         = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: scoreboard of expected deliveries plus directed state checks.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] instruction_address;
    logic [31:0] instruction_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .instruction_address (instruction_address),
        .instruction_data    (instruction_data),
        .stall               (stall),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .if_id_valid         (if_id_valid),
        .if_id_instr         (if_id_instr),
        .if_id_pc            (if_id_pc),
        .if_id_pc_plus4      (if_id_pc_plus4),
        .fetch_fault         (fetch_fault),
        .fetch_count         (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: two known program words, a tagged pattern elsewhere
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom_word = 32'h0050_0093;
            32'h0000_0004: rom_word = 32'h00A0_0113;
            default:       rom_word = 32'hC0DE_0000 | {16'h0000, a[15:0]};
        endcase
    endfunction

    assign instruction_data = rom_word(instruction_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
        exp_t e;
        e.instr    = instr;
        e.pc       = pc;
        e.pc_plus4 = pc4;
        exp_q.push_back(e);
    endtask

    // Monitor: a new delivery is a valid IF/ID slot whose fetch_count moved
    logic [31:0] last_count = 32'd0;
    always @(negedge clk) begin
        if (!reset && if_id_valid && (fetch_count != last_count)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery actual_pc=%h required=none", if_id_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("deliv_instr", if_id_instr, e.instr);
                chk("deliv_pc", if_id_pc, e.pc);
                chk("deliv_pc_plus4", if_id_pc_plus4, e.pc_plus4);
                chk("deliv_count_step", fetch_count, last_count + 32'd1);
            end
        end
        last_count = fetch_count;
    end

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        @(negedge clk);

        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'h0000_0013);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_pc4", if_id_pc_plus4, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", instruction_address, 32'd0);

        // Sequential fetch
        push(32'h0050_0093, 32'h0, 32'h4);
        push(32'h00A0_0113, 32'h4, 32'h8);
        push(32'hC0DE_0008, 32'h8, 32'hC);
        reset = 1'b0;
        @(negedge clk);
        chk("seq1_valid", {31'd0, if_id_valid}, 32'd1);
        @(negedge clk);
        chk("seq2_count", fetch_count, 32'd2);
        chk("seq2_pc4", if_id_pc_plus4, 32'h8);
        @(negedge clk);
        chk("seq3_addr", instruction_address, 32'hC);

        // Stall for three cycles with IF/ID at pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc", if_id_pc, 32'h8);
            chk("stall_instr", if_id_instr, 32'hC0DE_0008);
            chk("stall_addr", instruction_address, 32'hC);
            chk("stall_count", fetch_count, 32'd3);
        end
        stall = 1'b0;
        push(32'hC0DE_000C, 32'hC, 32'h10);
        @(negedge clk);
        chk("resume_addr", instruction_address, 32'h10);

        // Redirect overrides a simultaneous stall
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        stall          = 1'b1;
        @(negedge clk);
        chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("redir_instr", if_id_instr, 32'h0000_0013);
        chk("redir_addr", instruction_address, 32'h40);
        chk("redir_count", fetch_count, 32'd4);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        push(32'hC0DE_0040, 32'h40, 32'h44);
        @(negedge clk);

        // Out-of-range: last ROM word delivered, then fault at 0x400
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FC;
        @(negedge clk);
        redirect_valid = 1'b0;
        push(32'hC0DE_03FC, 32'h3FC, 32'h400);
        @(negedge clk);
        chk("oor_addr", instruction_address, 32'h400);
        chk("oor_nofault_yet", {31'd0, fetch_fault}, 32'd0);
        @(negedge clk);
        chk("oor_fault", {31'd0, fetch_fault}, 32'd1);
        chk("oor_valid", {31'd0, if_id_valid}, 32'd0);
        chk("oor_addr_frozen", instruction_address, 32'h400);
        chk("oor_count", fetch_count, 32'd6);

        // Asynchronous reset between edges while faulted
        #3;
        reset = 1'b1;
        #1;
        chk("arst_addr", instruction_address, 32'd0);
        chk("arst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst_instr", if_id_instr, 32'h0000_0013);
        @(negedge clk);
        push(32'h0050_0093, 32'h0, 32'h4);
        reset = 1'b0;
        @(negedge clk);

        // Misaligned redirect -> sticky fault
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        @(negedge clk);
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_valid", {31'd0, if_id_valid}, 32'd0);
        chk("mis_addr", instruction_address, 32'h4);
        for (int i = 0; i < 10; i++) begin
            stall          = (i % 2) == 1;
            redirect_valid = (i % 3) != 0;
            redirect_pc    = ((i % 4) < 2) ? 32'h80 : 32'h22;
            @(negedge clk);
            chk("flt_fault", {31'd0, fetch_fault}, 32'd1);
            chk("flt_valid", {31'd0, if_id_valid}, 32'd0);
            chk("flt_instr", if_id_instr, 32'h0000_0013);
            chk("flt_addr", instruction_address, 32'h4);
            chk("flt_count", fetch_count, 32'd1);
        end
        redirect_valid = 1'b0;
        stall          = 1'b0;

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the single-cycle-read instruction ROM: owns the PC, drives the ROM address, captures the returned word into an IF/ID pipeline register for decode.
- Sits inside cpu between the instruction memory port and the decode stage.
- Handles stall, branch/jump redirect with flush, and a sticky fetch-fault state.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction_address.
- DATA_WIDTH, 32, instruction word width.
- MEM_DEPTH_BYTES, 1024, size of instruction ROM; fetches at or above this address fault.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- instruction_address  output  ADDR_WIDTH  byte address to ROM; equals current PC, combinational from the PC register.
- instruction_data  input  DATA_WIDTH  ROM read data, valid in the same cycle as the address.
- stall  input  1  decode cannot accept; hold PC and IF/ID.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  ADDR_WIDTH  redirect target.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_instr  output  DATA_WIDTH  captured instruction.
- if_id_pc  output  ADDR_WIDTH  address of captured instruction.
- if_id_pc_plus4  output  ADDR_WIDTH  if_id_pc + 4.
- fetch_fault  output  1  sticky fault indicator.
- fetch_count  output  32  number of instructions delivered into IF/ID.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=RUN, if_id_valid=0, if_id_instr=NOP (32'h0000_0013), if_id_pc=0, if_id_pc_plus4=0, fetch_fault=0, fetch_count=0.
- FSM states: RUN, FAULT. RUN→FAULT on a fault condition. FAULT is exited only by reset.
- RUN, priority order evaluated each rising edge:
  1. redirect_valid=1 with redirect_pc[1:0]!=0 → FAULT, fetch_fault=1, if_id_valid=0, pc unchanged.
  2. redirect_valid=1 (aligned) → pc<=redirect_pc, if_id_valid<=0 (flush), instr<=NOP. Redirect overrides stall.
  3. stall=1 → pc and all IF/ID fields hold; fetch_count holds.
  4. pc > MEM_DEPTH_BYTES-4 → FAULT, fetch_fault=1, if_id_valid<=0, word not delivered.
  5. Otherwise → if_id_valid<=1, if_id_instr<=instruction_data, if_id_pc<=pc, if_id_pc_plus4<=pc+4, pc<=pc+4, fetch_count<=fetch_count+1.
- Fetch latency: an address presented in cycle N appears in IF/ID after edge N. First valid instruction is visible one cycle after reset release.
- FAULT: pc frozen; if_id_valid=0; instr=NOP; stall and redirect are ignored; fetch_count frozen.
- Arithmetic: pc+4 and fetch_count wrap modulo 2^width. No saturation.
- Reset asserted mid-stall or mid-fault returns every output to its reset value immediately, without waiting for a clock edge.

Decomposition:
- fetch_pkg holds:
  - NOP constant (32'h0000_0013).
  - fetch_state_t enum {RUN, FAULT}.
  - if_id_t packed struct {valid, instr, pc, pc_plus4}, shared with the decode stage.
- Sub-module if_id_reg: holds the if_id_t register with load/flush/hold controls and async reset to {0, NOP, 0, 0}. The FSM and PC logic stay in fetch_unit.

Test Plan:
- Sequential fetch: ROM word0=32'h00500093, word1=32'h00A00113; release reset → cycle 1 gives valid=1, instr=32'h00500093, pc=0; cycle 2 gives instr=32'h00A00113, pc=4, pc_plus4=8, fetch_count=2.
- Stall: assert stall for 3 cycles with IF/ID at pc=8 → IF/ID, instruction_address=12, and fetch_count are unchanged for all 3 cycles; the fetch resumes at 12 on deassert.
- Redirect with simultaneous stall: redirect_valid=1, redirect_pc=32'h40, stall=1 → next cycle valid=0, instr=NOP, instruction_address=32'h40; following cycle pc=32'h40 is delivered.
- Misaligned redirect: redirect_pc=32'h22 → fetch_fault=1, valid=0, and the unit stays in this state for 10 cycles regardless of stall or redirect.
- Out-of-range: redirect to 32'h3FC, then free-run → word at 32'h3FC is delivered; at pc=32'h400 fetch_fault=1 and valid=0.
- Async reset mid-operation: assert reset between clock edges while in FAULT → pc=0, fetch_fault=0, fetch_count=0 immediately.
